// File: rtl/mem_io_ctrl.sv
// Memory-side address decoder and I/O block: steers stores to DMEM/IMEM/IO, returns load data
// one cycle later, and owns the UART handshake registers plus cycle/retire counters.
module mem_io_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_adr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  wea,
  input  logic        mem_re,
  input  logic        instr_retire,
  input  logic [31:0] dmem_dout,
  output logic [3:0]  dmem_we,
  output logic [3:0]  imem_we,
  output logic [31:0] din,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);

  localparam logic [3:0] RegDmem = 4'h1;
  localparam logic [3:0] RegImem = 4'h2;
  localparam logic [3:0] RegBoth = 4'h3;
  localparam logic [3:0] RegIo   = 4'h8;

  localparam logic [7:0] OffStatus = 8'h00;
  localparam logic [7:0] OffRxData = 8'h04;
  localparam logic [7:0] OffTxData = 8'h08;
  localparam logic [7:0] OffCycle  = 8'h10;
  localparam logic [7:0] OffInstr  = 8'h14;
  localparam logic [7:0] OffClear  = 8'h18;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [3:0]       region;
  logic [7:0]       offset;
  logic             is_store;
  logic             is_load;
  logic             dmem_region;
  logic             imem_region;
  logic             io_region;
  logic             tx_ready_eff;
  logic [31:0]      cyc_ext;
  logic [31:0]      ins_ext;
  logic [31:0]      io_rdata;

  logic             tx_pending_q, tx_pending_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             rx_ready_q, rx_ready_d;
  logic             rd_dmem_q, rd_dmem_d;
  logic [31:0]      io_rdata_q, io_rdata_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] ins_q, ins_d;

  // Address bits above the IO offset and store data above the UART byte are not decoded.
  logic unused_bits;
  assign unused_bits = ^{mem_adr[27:8], mem_wdata[31:8]};

  assign region = mem_adr[31:28];
  assign offset = mem_adr[7:0];

  always_comb begin
    is_store     = |wea;
    // A request carrying both mem_re and a write enable is a store only.
    is_load      = mem_re & ~is_store;
    dmem_region  = (region == RegDmem) || (region == RegBoth);
    imem_region  = (region == RegImem) || (region == RegBoth);
    io_region    = (region == RegIo);
    tx_ready_eff = uart_tx_ready & ~tx_pending_q;
    dmem_we      = dmem_region ? wea : 4'b0000;
    imem_we      = imem_region ? wea : 4'b0000;
  end

  always_comb begin
    cyc_ext = '0;
    ins_ext = '0;
    cyc_ext[CNT_W-1:0] = cyc_q;
    ins_ext[CNT_W-1:0] = ins_q;
  end

  always_comb begin
    io_rdata = '0;
    case (offset)
      OffStatus: io_rdata = {30'b0, uart_rx_valid, tx_ready_eff};
      OffRxData: io_rdata = {24'b0, uart_rx_data};
      OffCycle:  io_rdata = cyc_ext;
      OffInstr:  io_rdata = ins_ext;
      default:   io_rdata = '0;
    endcase
  end

  always_comb begin
    tx_pending_d = tx_pending_q;
    tx_data_d    = tx_data_q;
    rx_ready_d   = 1'b0;
    rd_dmem_d    = is_load & dmem_region;
    io_rdata_d   = (is_load && io_region) ? io_rdata : 32'h0;
    cyc_d        = cyc_q + CntOne;
    ins_d        = instr_retire ? (ins_q + CntOne) : ins_q;

    if (tx_pending_q && uart_tx_ready) begin
      tx_pending_d = 1'b0;
    end

    if (is_store && io_region && (offset == OffTxData) && tx_ready_eff) begin
      tx_data_d    = mem_wdata[7:0];
      tx_pending_d = 1'b1;
    end

    if (is_load && io_region && (offset == OffRxData) && uart_rx_valid) begin
      rx_ready_d = 1'b1;
    end

    // Clear wins over the same-edge increment.
    if (is_store && io_region && (offset == OffClear)) begin
      cyc_d = '0;
      ins_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_pending_q <= 1'b0;
      tx_data_q    <= 8'h00;
      rx_ready_q   <= 1'b0;
      rd_dmem_q    <= 1'b0;
      io_rdata_q   <= 32'h0;
      cyc_q        <= '0;
      ins_q        <= '0;
    end else begin
      tx_pending_q <= tx_pending_d;
      tx_data_q    <= tx_data_d;
      rx_ready_q   <= rx_ready_d;
      rd_dmem_q    <= rd_dmem_d;
      io_rdata_q   <= io_rdata_d;
      cyc_q        <= cyc_d;
      ins_q        <= ins_d;
    end
  end

  // DMEM read data arrives from the BRAM in the cycle after the request.
  assign din           = rd_dmem_q ? dmem_dout : io_rdata_q;
  assign uart_tx_data  = tx_data_q;
  assign uart_tx_valid = tx_pending_q;
  assign uart_rx_ready = rx_ready_q;

endmodule
